// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: gates player inputs by game state, counts lives, times phases on frame pulses.
// Optional feature: define GRACE_EN for post-respawn enemy immunity.
module game_flow_ctrl #(
    parameter int MAX_LIVES      = 3,
    parameter int DEATH_Y        = 470,
    parameter int RESPAWN_FRAMES = 30,
    parameter int DYING_FRAMES   = 60,
    parameter int WIN_FRAMES     = 90,
    parameter int GRACE_FRAMES   = 45
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               startOfFrame_i,
    input  logic               startIsPressed_i,
    input  logic               jumpIsPressed_i,
    input  logic               digitIsPressed_i,
    input  logic [3:0]         digit_i,
    input  logic               enemyCollision_i,
    input  logic               goalCollision_i,
    input  logic signed [10:0] monkeyY_i,
    output logic               jumpOut_o,
    output logic               digitIsPressedOut_o,
    output logic [3:0]         digitOut_o,
    output logic               monkeyResetN_o,
    output logic [1:0]         lives_o,
    output logic [2:0]         gameState_o,
    output logic               levelDone_o
);

    // state    | meaning
    // ATTRACT  | idle title screen, waits for start
    // PLAY     | inputs pass to the mover
    // DYING    | death animation
    // RESPAWN  | mover held/reset, then play resumes
    // WIN      | level-complete display
    // GAMEOVER | no lives left, waits for start
    localparam logic [2:0] ST_ATTRACT  = 3'd0;
    localparam logic [2:0] ST_PLAY     = 3'd1;
    localparam logic [2:0] ST_DYING    = 3'd2;
    localparam logic [2:0] ST_RESPAWN  = 3'd3;
    localparam logic [2:0] ST_WIN      = 3'd4;
    localparam logic [2:0] ST_GAMEOVER = 3'd5;

    localparam logic [1:0]         LIVES_INIT  = 2'(MAX_LIVES);
    localparam logic signed [10:0] DEATH_Y_S   = 11'(DEATH_Y);
    localparam logic [7:0]         RESP_LAST   = 8'(RESPAWN_FRAMES - 1);
    localparam logic [7:0]         DYING_LAST  = 8'(DYING_FRAMES - 1);
    localparam logic [7:0]         WIN_LAST    = 8'(WIN_FRAMES - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       monkey_reset_n_q, monkey_reset_n_d;
    logic       level_done_q, level_done_d;
    logic       enemy_kills;
    logic       dead;

`ifdef GRACE_EN
    logic [7:0] grace_cnt_q, grace_cnt_d;
    assign enemy_kills = enemyCollision_i && (grace_cnt_q == 8'd0);
`else
    assign enemy_kills = enemyCollision_i;
`endif

    assign dead = (monkeyY_i > DEATH_Y_S) || enemy_kills;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        case (state_q)
            ST_ATTRACT, ST_GAMEOVER: begin
                if (startIsPressed_i) begin
                    state_d = ST_RESPAWN;
                    lives_d = LIVES_INIT;
                end
            end
            ST_RESPAWN: begin
                if (startOfFrame_i && frame_cnt_q == RESP_LAST) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (dead) begin
                    state_d = ST_DYING;
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end else if (goalCollision_i) begin
                    state_d = ST_WIN;
                end
            end
            ST_DYING: begin
                if (startOfFrame_i && frame_cnt_q == DYING_LAST)
                    state_d = (lives_q == 2'd0) ? ST_GAMEOVER : ST_RESPAWN;
            end
            ST_WIN: begin
                if (startOfFrame_i && frame_cnt_q == WIN_LAST) state_d = ST_RESPAWN;
            end
            default: state_d = ST_ATTRACT;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q)  frame_cnt_d = 8'd0;
        else if (startOfFrame_i) frame_cnt_d = frame_cnt_q + 8'd1;
    end

    // Low for exactly the one cycle following RESPAWN entry.
    assign monkey_reset_n_d = !((state_d == ST_RESPAWN) && (state_q != ST_RESPAWN));
    assign level_done_d     = (state_d == ST_WIN);

`ifdef GRACE_EN
    always_comb begin
        grace_cnt_d = 8'd0;
        if (state_q == ST_RESPAWN && state_d == ST_PLAY) begin
            grace_cnt_d = 8'(GRACE_FRAMES);
        end else if (state_q == ST_PLAY && state_d == ST_PLAY) begin
            grace_cnt_d = grace_cnt_q;
            if (startOfFrame_i && grace_cnt_q != 8'd0) grace_cnt_d = grace_cnt_q - 8'd1;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= ST_ATTRACT;
            lives_q          <= LIVES_INIT;
            frame_cnt_q      <= 8'd0;
            monkey_reset_n_q <= 1'b1;
            level_done_q     <= 1'b0;
`ifdef GRACE_EN
            grace_cnt_q      <= 8'd0;
`endif
        end else begin
            state_q          <= state_d;
            lives_q          <= lives_d;
            frame_cnt_q      <= frame_cnt_d;
            monkey_reset_n_q <= monkey_reset_n_d;
            level_done_q     <= level_done_d;
`ifdef GRACE_EN
            grace_cnt_q      <= grace_cnt_d;
`endif
        end
    end

    assign jumpOut_o           = (state_q == ST_PLAY) && jumpIsPressed_i;
    assign digitIsPressedOut_o = (state_q == ST_PLAY) && digitIsPressed_i;
    assign digitOut_o          = (state_q == ST_PLAY) ? digit_i : 4'd0;
    assign monkeyResetN_o      = monkey_reset_n_q;
    assign lives_o             = lives_q;
    assign gameState_o         = state_q;
    assign levelDone_o         = level_done_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl; follows GRACE_EN when the macro is defined.
module tb_game_flow_ctrl;

    logic               clk = 1'b0;
    logic               reset, sof, start, jump, dig_press, enemy, goal;
    logic [3:0]         digit;
    logic signed [10:0] monkey_y;
    logic               jump_out, dig_press_out, mrn, level_done;
    logic [3:0]         digit_out;
    logic [1:0]         lives;
    logic [2:0]         gstate;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_flow_ctrl dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .startOfFrame_i      (sof),
        .startIsPressed_i    (start),
        .jumpIsPressed_i     (jump),
        .digitIsPressed_i    (dig_press),
        .digit_i             (digit),
        .enemyCollision_i    (enemy),
        .goalCollision_i     (goal),
        .monkeyY_i           (monkey_y),
        .jumpOut_o           (jump_out),
        .digitIsPressedOut_o (dig_press_out),
        .digitOut_o          (digit_out),
        .monkeyResetN_o      (mrn),
        .lives_o             (lives),
        .gameState_o         (gstate),
        .levelDone_o         (level_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; sof = 1'b0; start = 1'b0; jump = 1'b0; dig_press = 1'b0;
        enemy = 1'b0; goal = 1'b0; digit = 4'd0; monkey_y = 11'sd100;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_state", 8'(gstate), 8'd0);
        check("rst_lives", 8'(lives), 8'd3);
        check("rst_mrn", 8'(mrn), 8'd1);
        check("rst_done", 8'(level_done), 8'd0);
        jump = 1'b1; digit = 4'd6; dig_press = 1'b1;
        #1;
        check("attract_jump", 8'(jump_out), 8'd0);
        check("attract_digit", 8'(digit_out), 8'd0);
        jump = 1'b0; dig_press = 1'b0; digit = 4'd0;

        // start -> RESPAWN with one-cycle reset pulse
        start = 1'b1; tick(); start = 1'b0;
        check("start_state", 8'(gstate), 8'd3);
        check("start_mrn_low", 8'(mrn), 8'd0);
        tick();
        check("start_mrn_high", 8'(mrn), 8'd1);
        frames(29);
        check("resp_29", 8'(gstate), 8'd3);
        frames(1);
        check("resp_30", 8'(gstate), 8'd1);

        jump = 1'b1; dig_press = 1'b1; digit = 4'd6;
        #1;
        check("play_jump", 8'(jump_out), 8'd1);
        check("play_dpress", 8'(dig_press_out), 8'd1);
        check("play_digit", 8'(digit_out), 8'd6);
        jump = 1'b0; dig_press = 1'b0; digit = 4'd0;

        // enemy death, with grace window when enabled
        frames(10);
        enemy = 1'b1; tick(); enemy = 1'b0;
`ifdef GRACE_EN
        check("grace_f10", 8'(gstate), 8'd1);
        frames(36);
        enemy = 1'b1; tick(); enemy = 1'b0;
`endif
        check("enemy_state", 8'(gstate), 8'd2);
        check("enemy_lives", 8'(lives), 8'd2);
        frames(59);
        check("dying_59", 8'(gstate), 8'd2);
        frames(1);
        check("dying_60", 8'(gstate), 8'd3);
        frames(30);
        check("respawn2", 8'(gstate), 8'd1);

        // win with gating held
        goal = 1'b1; tick(); goal = 1'b0;
        dig_press = 1'b1; digit = 4'd6;
        #1;
        check("win_state", 8'(gstate), 8'd4);
        check("win_done", 8'(level_done), 8'd1);
        check("win_digit", 8'(digit_out), 8'd0);
        check("win_dpress", 8'(dig_press_out), 8'd0);
        frames(89);
        check("win_89", 8'(gstate), 8'd4);
        check("win_89_digit", 8'(digit_out), 8'd0);
        frames(1);
        check("win_90", 8'(gstate), 8'd3);
        check("win_90_done", 8'(level_done), 8'd0);
        check("win_lives", 8'(lives), 8'd2);
        dig_press = 1'b0; digit = 4'd0;
        frames(30);
        check("respawn3", 8'(gstate), 8'd1);

        // death beats goal
        goal = 1'b1; monkey_y = 11'sd480; tick(); goal = 1'b0; monkey_y = 11'sd100;
        check("both_state", 8'(gstate), 8'd2);
        check("both_done", 8'(level_done), 8'd0);
        check("both_lives", 8'(lives), 8'd1);
        frames(60);
        frames(30);
        check("respawn4", 8'(gstate), 8'd1);

        // fall boundary and signed compare
        monkey_y = 11'sd470; tick();
        check("y470_alive", 8'(gstate), 8'd1);
        monkey_y = -11'sd5; tick();
        check("yneg_alive", 8'(gstate), 8'd1);
        monkey_y = 11'sd471; tick(); monkey_y = 11'sd100;
        check("y471_dead", 8'(gstate), 8'd2);
        check("last_lives", 8'(lives), 8'd0);
        jump = 1'b1;
        frames(60);
        check("gameover", 8'(gstate), 8'd5);
        check("go_jump", 8'(jump_out), 8'd0);
        check("go_lives", 8'(lives), 8'd0);
        jump = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
        check("restart_state", 8'(gstate), 8'd3);
        check("restart_lives", 8'(lives), 8'd3);
        check("restart_mrn", 8'(mrn), 8'd0);

        // reset mid-RESPAWN
        frames(5);
        reset = 1'b1; sof = 1'b1; tick(); reset = 1'b0; sof = 1'b0;
        check("midrst_state", 8'(gstate), 8'd0);
        check("midrst_mrn", 8'(mrn), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
